// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the time keeper, alarm comparator and display mux.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR24_MAX = 23;
  localparam int unsigned HR12_MIN = 1;
  localparam int unsigned HR12_MAX = 12;

  // Binary 0..99 to packed {tens, ones} BCD.
  function automatic logic [7:0] to_bcd2(input logic [7:0] v);
    logic [7:0] t;
    logic [7:0] o;
    t = v / 8'd10;
    o = v % 8'd10;
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MAX; carry_out fires on the increment that wraps MAX -> 00.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry_out
);

  localparam bcd_t TensMax = 4'(MAX / 10);
  localparam bcd_t OnesMax = 4'(MAX % 10);

  logic at_max;
  logic illegal;
  bcd_t tens_d;
  bcd_t ones_d;

  always_comb begin
    at_max    = (tens == TensMax) && (ones == OnesMax);
    illegal   = (ones > 4'd9) || (tens > TensMax) || ((tens == TensMax) && (ones > OnesMax));
    carry_out = inc & ~clr & at_max;
    tens_d    = tens;
    ones_d    = ones;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      // Corrupted values fall back to 00 rather than counting on from garbage.
      if (at_max || illegal) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones == 4'd9) begin
        tens_d = tens + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else begin
      tens <= tens_d;
      ones <= ones_d;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a 1 Hz square wave,
// with a button-driven set mode and optional 12-hour display with AM/PM.
module time_keeper
  import clock_pkg::*;
#(
  parameter bit TWELVE_HR = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  input  logic set_en,
  input  logic inc_min,
  input  logic inc_hr,
  input  logic clr_sec,
  output bcd_t hr_t,
  output bcd_t hr_o,
  output bcd_t min_t,
  output bcd_t min_o,
  output bcd_t sec_t,
  output bcd_t sec_o,
  output logic pm,
  output logic sec_pulse,
  output logic day_wrap
);

  localparam bcd_t       HrRstT = TWELVE_HR ? 4'd1 : 4'd0;
  localparam bcd_t       HrRstO = TWELVE_HR ? 4'd2 : 4'd0;
  localparam logic [7:0] Hr24Max = 8'(HR24_MAX);
  localparam logic [7:0] Hr12Min = 8'(HR12_MIN);
  localparam logic [7:0] Hr12Max = 8'(HR12_MAX);

  logic       tick_q;
  logic       tick;
  logic       run_tick;
  logic       sec_carry;
  logic       min_carry;
  logic       min_inc;
  logic       hr_inc;
  logic       hr_ok;
  logic [7:0] hr_val;
  logic [7:0] hr_nxt;
  bcd_t       hr_t_d;
  bcd_t       hr_o_d;
  logic       pm_d;
  logic       wrap_d;

  assign tick     = tick_in & ~tick_q;
  assign run_tick = tick & ~set_en;
  // Set-mode minute bumps must not carry into hours.
  assign min_inc  = (~set_en & sec_carry) | (set_en & inc_min);
  assign hr_inc   = (~set_en & min_carry) | (set_en & inc_hr);

  bcd2_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (run_tick),
    .clr       (set_en & clr_sec),
    .tens      (sec_t),
    .ones      (sec_o),
    .carry_out (sec_carry)
  );

  bcd2_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (min_inc),
    .clr       (1'b0),
    .tens      (min_t),
    .ones      (min_o),
    .carry_out (min_carry)
  );

  always_comb begin
    hr_val = ({4'd0, hr_t} * 8'd10) + {4'd0, hr_o};
    hr_ok  = (hr_o <= 4'd9) && (hr_t <= 4'd2);
    hr_nxt = hr_val;
    pm_d   = pm;
    wrap_d = 1'b0;
    if (hr_inc) begin
      if (TWELVE_HR) begin
        // 12-hour mode recovers to 12 since 00 is not a displayable hour there.
        if (!hr_ok || (hr_val > Hr12Max) || (hr_val == 8'd0)) begin
          hr_nxt = Hr12Max;
        end else if (hr_val == Hr12Max) begin
          hr_nxt = Hr12Min;
        end else if (hr_val == Hr12Max - 8'd1) begin
          hr_nxt = Hr12Max;
          pm_d   = ~pm;
          wrap_d = ~set_en & pm;
        end else begin
          hr_nxt = hr_val + 8'd1;
        end
      end else begin
        if (!hr_ok || (hr_val >= Hr24Max)) begin
          hr_nxt = 8'd0;
          wrap_d = ~set_en & hr_ok & (hr_val == Hr24Max);
        end else begin
          hr_nxt = hr_val + 8'd1;
        end
      end
    end
    {hr_t_d, hr_o_d} = to_bcd2(hr_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      hr_t      <= HrRstT;
      hr_o      <= HrRstO;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      tick_q    <= tick_in;
      hr_t      <= hr_t_d;
      hr_o      <= hr_o_d;
      pm        <= pm_d;
      sec_pulse <= run_tick;
      day_wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: 24 h and 12 h instances share stimulus and are checked
// every cycle against a seconds-of-day reference model.
module tb_time_keeper;

  typedef struct packed {
    logic [3:0] ht, ho, mt, mo, st, so;
    logic       pm, sp, dw;
  } view_t;

  typedef struct {
    int    cyc;
    view_t v24;
    view_t v12;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0, set_en = 1'b0, inc_min = 1'b0, inc_hr = 1'b0, clr_sec = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic       a_pm, a_sp, a_dw;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic       b_pm, b_sp, b_dw;
  view_t      dv24, dv12;

  assign dv24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_pm, a_sp, a_dw};
  assign dv12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_pm, b_sp, b_dw};

  time_keeper #(.TWELVE_HR(1'b0)) u_dut24 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en), .inc_min(inc_min),
    .inc_hr(inc_hr), .clr_sec(clr_sec), .hr_t(a_ht), .hr_o(a_ho), .min_t(a_mt), .min_o(a_mo),
    .sec_t(a_st), .sec_o(a_so), .pm(a_pm), .sec_pulse(a_sp), .day_wrap(a_dw)
  );

  time_keeper #(.TWELVE_HR(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en), .inc_min(inc_min),
    .inc_hr(inc_hr), .clr_sec(clr_sec), .hr_t(b_ht), .hr_o(b_ho), .min_t(b_mt), .min_o(b_mo),
    .sec_t(b_st), .sec_o(b_so), .pm(b_pm), .sec_pulse(b_sp), .day_wrap(b_dw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  // Reference model: time as seconds since midnight, 24 h internally.
  int secs = 0;
  bit prev_tick = 1'b0;
  bit m_sp = 1'b0;
  bit m_dw = 1'b0;

  function automatic view_t proj(input int s, input bit twelve, input bit sp, input bit dw);
    int    h, m, x, hd;
    view_t v;
    h  = s / 3600;
    m  = (s / 60) % 60;
    x  = s % 60;
    hd = twelve ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    v.ht = 4'(hd / 10);
    v.ho = 4'(hd % 10);
    v.mt = 4'(m / 10);
    v.mo = 4'(m % 10);
    v.st = 4'(x / 10);
    v.so = 4'(x % 10);
    v.pm = twelve && (h >= 12);
    v.sp = sp;
    v.dw = dw;
    return v;
  endfunction

  function automatic string fmt(input view_t v);
    return $sformatf("%0h%0h:%0h%0h:%0h%0h pm=%0b sp=%0b dw=%0b",
                     v.ht, v.ho, v.mt, v.mo, v.st, v.so, v.pm, v.sp, v.dw);
  endfunction

  task automatic check(input string name, input view_t got, input view_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
  endtask

  task automatic push(input int at);
    sb.push_back('{at, proj(secs, 1'b0, m_sp, m_dw), proj(secs, 1'b1, m_sp, m_dw)});
  endtask

  task automatic model_reset();
    secs = 0;
    prev_tick = 1'b0;
    m_sp = 1'b0;
    m_dw = 1'b0;
  endtask

  // One clock of stimulus; expectation is for the state after the next posedge.
  task automatic step(input bit ti, input bit se, input bit im, input bit ih, input bit cs);
    bit tk;
    int h, m, s;
    tick_in = ti; set_en = se; inc_min = im; inc_hr = ih; clr_sec = cs;
    tk = ti && !prev_tick;
    prev_tick = ti;
    m_sp = 1'b0;
    m_dw = 1'b0;
    if (!se) begin
      if (tk) begin
        secs = (secs + 1) % 86400;
        m_sp = 1'b1;
        m_dw = (secs == 0);
      end
    end else begin
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      if (cs) s = 0;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      secs = h * 3600 + m * 60 + s;
    end
    push(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Enters set mode, moves to hh:mm:00 with button pulses, stays in set mode.
  task automatic set_hm(input int h, input int m);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (secs / 3600 != h) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    while ((secs / 60) % 60 != m) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic leave_set();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check($sformatf("h24@%0d", e.cyc), dv24, e.v24);
      check($sformatf("h12@%0d", e.cyc), dv12, e.v12);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push(cyc);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Held-high tick counts once.
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Midnight wrap in 24 h.
    set_hm(23, 59);
    leave_set();
    tick_n(59);
    tick_n(2);

    // inc_min wraps without carry; combined inc_hr + inc_min.
    set_hm(0, 59);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_hm(5, 10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    leave_set();

    // 12 h transitions: 11 AM -> 12 PM, 12 PM -> 01 PM, 11 PM -> 12 AM.
    set_hm(11, 59);
    leave_set();
    tick_n(60);
    set_hm(12, 59);
    leave_set();
    tick_n(60);
    set_hm(23, 59);
    leave_set();
    tick_n(60);

    // Tick edge on a set-mode cycle is dropped; next edge counts.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random mix of ticks, set mode and button pulses.
    repeat (600) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count at 14:37:22.
    set_hm(14, 37);
    leave_set();
    tick_n(22);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_h24", dv24, proj(0, 1'b0, 1'b0, 1'b0));
    check("async_rst_h12", dv12, proj(0, 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_n(3);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Downstream consumer of the 1 Hz square wave from the clock divider. Detects each rising edge of that wave in the system clock domain and advances a BCD hours:minutes:seconds time-of-day count. Supports a user set mode driven by debounced single-cycle button pulses. Feeds the display multiplexer and the alarm comparator.

Parameters:
TWELVE_HR, 0, 0 = 24-hour count 00..23; 1 = 12-hour count 12,01..11 with AM/PM flag

Ports:
clk  input  1  system clock (same domain as the divider that drives tick_in)
rst  input  1  asynchronous, active-high reset
tick_in  input  1  1 Hz square wave from the divider; each rising edge is one second
set_en  input  1  level; 1 = set mode, time counting suspended
inc_min  input  1  single-cycle pulse; increment minutes (honoured only in set mode)
inc_hr  input  1  single-cycle pulse; increment hours (honoured only in set mode)
clr_sec  input  1  single-cycle pulse; zero seconds (honoured only in set mode)
hr_t, hr_o  output  4 each  hours tens/ones, BCD
min_t, min_o  output  4 each  minutes tens/ones, BCD
sec_t, sec_o  output  4 each  seconds tens/ones, BCD
pm  output  1  PM flag; constant 0 when TWELVE_HR=0
sec_pulse  output  1  one-cycle pulse on each counted second
day_wrap  output  1  one-cycle pulse when time wraps to midnight

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset state: TWELVE_HR=0 gives 00:00:00, pm=0; TWELVE_HR=1 gives 12:00:00, pm=0 (midnight AM). Also on reset: sec_pulse=0, day_wrap=0, and the edge register tick_q=0.
- Edge detect: tick_q <= tick_in every cycle. tick = tick_in & ~tick_q. A held-high tick_in counts exactly once. Reset while tick_in=1 followed by release causes one count on the first post-reset cycle. This is accepted.
- Run mode (set_en=0), on a cycle with tick=1:
  - The seconds advance. Outputs and sec_pulse are registered, so they are visible one cycle after the tick cycle.
  - Seconds wrap 59 -> 00 and carry to minutes. Minutes wrap 59 -> 00 and carry to hours.
  - 24 h: hours wrap 23 -> 00 and day_wrap pulses with that update.
  - 12 h: hours go 11 -> 12 and pm toggles. Hours go 12 -> 01 with no pm change. day_wrap pulses on the 11:59:59 PM -> 12:00:00 AM transition.
  - inc_min, inc_hr and clr_sec are ignored in run mode.
- Set mode (set_en=1):
  - Ticks are discarded, sec_pulse stays 0 and tick_q still tracks tick_in.
  - inc_min: minutes +1 mod 60, no carry into hours.
  - inc_hr: hours +1 (00..23 in 24 h; 12 -> 01 -> ... -> 11 -> 12 in 12 h, with pm toggling on 11 -> 12). day_wrap never pulses in set mode.
  - clr_sec: seconds become 00.
  - Any combination of simultaneous pulses is applied together in the same cycle.
- If a tick coincides with the cycle where set_en=1, the tick is dropped. Counting resumes with the first tick whose cycle has set_en=0.
- BCD digits never hold a value above 9. Tens digits stay within 0..5 (minutes/seconds) and 0..2 (hours). Any illegal state reached must recover to 00 on the next increment of that field.

Decomposition:
- Package clock_pkg holds: typedef bcd_t (4-bit), constants SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12. These are shared with the alarm comparator and the display multiplexer.
- Sub-module bcd2_counter: two-digit BCD counter with a modulo-limit parameter, inc and clr inputs, and a carry_out that fires on wrap. It is instantiated for seconds and minutes. Hours logic stays in time_keeper because of the 12/24 handling.

Test Plan:
- Reset with TWELVE_HR=0 -> all digits 0, pm=0, pulses 0. Hold tick_in high 10 cycles -> exactly one count to 00:00:01, with one sec_pulse.
- Set mode: 23 inc_hr and 59 inc_min pulses, one clr_sec, then set_en=0 and 59 ticks -> 23:59:59. Next tick -> 00:00:00 and day_wrap=1 for exactly one cycle.
- Set mode at 00:59:xx: inc_min -> 00:00:xx with hours unchanged. inc_hr and inc_min in the same cycle from 05:10 -> 06:11.
- TWELVE_HR=1: set 11:59:59 AM, tick -> 12:00:00, pm=1. Continue to 12:59:59 PM, tick -> 01:00:00, pm=1. Set 11:59:59 PM, tick -> 12:00:00, pm=0, day_wrap=1.
- Tick rising on the cycle with set_en=1 -> no change and no sec_pulse. Next tick after set_en=0 -> seconds advance by 1.
- Assert rst asynchronously mid-count at 14:37:22 -> outputs return to reset values without waiting for a clk edge. Counting restarts cleanly on the next tick.
